// File: rtl/multi_sig_debouncer.sv
// N-channel button conditioner: synchroniser, ena-tick debounce, rise/fall pulses,
// and long-press detection with optional auto-repeat; channels are fully independent.
module multi_sig_debouncer #(
  parameter int N_CHANNELS      = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 10,
  parameter int HOLD_CYCLES     = 500,
  parameter int REPEAT_CYCLES   = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [N_CHANNELS-1:0] sig_in,
  output logic [N_CHANNELS-1:0] sig_debounced,
  output logic [N_CHANNELS-1:0] rise,
  output logic [N_CHANNELS-1:0] fall,
  output logic [N_CHANNELS-1:0] held,
  output logic [N_CHANNELS-1:0] rpt
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HOLD_T   = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] RPT_T    = HW'(REPEAT_CYCLES);
  localparam logic [HW-1:0] HCNT_SAT = {HW{1'b1}};
  localparam bit            RPT_EN   = (REPEAT_CYCLES > 0);

  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DW-1:0]          dcnt;
    logic [HW-1:0]          hcnt;
    logic [HW-1:0]          hcnt_inc;
    logic                   deb_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   held_q;
    logic                   rpt_q;
    logic                   s;
    logic                   mismatch;
    logic                   toggle;
    logic                   hit;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in[i]};
      end
    end

    assign s        = sync_q[SYNC_STAGES-1];
    assign mismatch = (s != deb_q);
    // The toggle needs the mismatch still present on the final counted tick, so a
    // glitch of DEBOUNCE_CYCLES enabled samples or fewer never changes the level.
    assign toggle   = ena && mismatch && (dcnt == DEB_LAST);
    assign hcnt_inc = (hcnt == HCNT_SAT) ? hcnt : hcnt + 1'b1;
    assign hit      = held_q ? (RPT_EN && (hcnt_inc == RPT_T)) : (hcnt_inc == HOLD_T);

    always_ff @(posedge clk) begin
      if (rst) begin
        dcnt   <= '0;
        deb_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (ena) begin
          if (!mismatch) begin
            dcnt <= '0;
          end else if (toggle) begin
            dcnt   <= '0;
            deb_q  <= s;
            rise_q <= s;
            fall_q <= ~s;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
      end
    end

    // Long-press: first rpt coincides with held rising, then one per repeat period.
    always_ff @(posedge clk) begin
      if (rst) begin
        hcnt   <= '0;
        held_q <= 1'b0;
        rpt_q  <= 1'b0;
      end else begin
        rpt_q <= 1'b0;
        if (toggle || !deb_q) begin
          hcnt   <= '0;
          held_q <= 1'b0;
        end else if (ena) begin
          if (hit) begin
            hcnt   <= '0;
            held_q <= 1'b1;
            rpt_q  <= 1'b1;
          end else begin
            hcnt <= hcnt_inc;
          end
        end
      end
    end

    assign sig_debounced[i] = deb_q;
    assign rise[i]          = rise_q;
    assign fall[i]          = fall_q;
    assign held[i]          = held_q;
    assign rpt[i]           = rpt_q;
  end

endmodule

// File: tb/tb_multi_sig_debouncer.sv
// Scoreboard bench for multi_sig_debouncer: expected pulse/held events are queued
// as stimulus is applied and matched by a negedge monitor as the DUT emits them.
module tb_multi_sig_debouncer;

  localparam int N      = 4;
  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_RPT  = 2;
  localparam int K_HON  = 3;
  localparam int K_HOFF = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic [N-1:0] sig_in;
  logic [N-1:0] sig_debounced;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] held;
  logic [N-1:0] rpt;

  int           cyc      = 0;
  int           n_checks = 0;
  int           n_errors = 0;
  bit           ena_mode = 1'b0;
  logic [N-1:0] held_prev = '0;
  int           exp_q[$];

  multi_sig_debouncer #(
    .N_CHANNELS     (N),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(3),
    .HOLD_CYCLES    (10),
    .REPEAT_CYCLES  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .sig_in       (sig_in),
    .sig_debounced(sig_debounced),
    .rise         (rise),
    .fall         (fall),
    .held         (held),
    .rpt          (rpt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Event code: cycle*64 + channel*8 + kind
  task automatic push(input int c, input int ch, input int kind);
    exp_q.push_back(c * 64 + ch * 8 + kind);
  endtask

  task automatic observe(input int ch, input int kind);
    int act;
    act = cyc * 64 + ch * 8 + kind;
    if (exp_q.size() == 0) check("unexpected_event", act, -1);
    else check("event", act, exp_q.pop_front());
  endtask

  always @(negedge clk) begin
    for (int c = 0; c < N; c++) begin
      if (rise[c]) observe(c, K_RISE);
      if (fall[c]) observe(c, K_FALL);
      if (rpt[c]) observe(c, K_RPT);
      if (held[c] && !held_prev[c]) observe(c, K_HON);
      if (!held[c] && held_prev[c]) observe(c, K_HOFF);
    end
    held_prev = held;
  end

  task automatic step();
    @(posedge clk);
    #1;
    ena = ena_mode ? ((cyc + 1) % 4 == 0) : 1'b1;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) step();
    check("queue_drained", exp_q.size(), 0);
    repeat (6) step();
  endtask

  // nth enabled edge at or after 'start' when ena fires on every 4th edge
  function automatic int nth_en(input int start, input int n);
    int cnt;
    cnt = 0;
    for (int e = start; e < start + 1000; e++) begin
      if (e % 4 == 0) begin
        cnt++;
        if (cnt == n) return e;
      end
    end
    return -1;
  endfunction

  initial begin
    int k;
    int r;
    int f;

    // Reset with all inputs high, then release and let all channels rise together
    rst    = 1'b1;
    ena    = 1'b1;
    sig_in = '1;
    for (int c = 0; c < N; c++) push(8, c, K_RISE);
    for (int c = 0; c < N; c++) push(14, c, K_FALL);
    step_to(2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_sig_debounced", sig_debounced, 0);
    check("rst_rise", rise, 0);
    check("rst_fall", fall, 0);
    check("rst_held", held, 0);
    check("rst_rpt", rpt, 0);
    step_to(7);
    @(negedge clk);
    check("pre_rise_level", sig_debounced, 0);
    step_to(8);
    @(negedge clk);
    check("post_rst_level", sig_debounced, 4'hF);
    sig_in = '0;
    drain();

    // 3-clk glitch on ch0 is rejected
    k = cyc;
    sig_in[0] = 1'b1;
    step_to(k + 3);
    sig_in[0] = 1'b0;
    step_to(k + 14);
    @(negedge clk);
    check("glitch_level", sig_debounced[0], 0);
    drain();

    // 4-clk pulse on ch0 is the shortest that gets through
    k = cyc;
    push(k + 6, 0, K_RISE);
    push(k + 10, 0, K_FALL);
    sig_in[0] = 1'b1;
    step_to(k + 4);
    sig_in[0] = 1'b0;
    drain();

    // Short press on ch1
    k = cyc;
    push(k + 6, 1, K_RISE);
    push(k + 14, 1, K_FALL);
    sig_in[1] = 1'b1;
    step_to(k + 5);
    @(negedge clk);
    check("press_before", sig_debounced[1], 0);
    step_to(k + 6);
    @(negedge clk);
    check("press_level", sig_debounced[1], 1);
    step_to(k + 8);
    sig_in[1] = 1'b0;
    drain();

    // Long press on ch2 with auto-repeat
    k = cyc;
    r = k + 6;
    push(r, 2, K_RISE);
    push(r + 10, 2, K_RPT);
    push(r + 10, 2, K_HON);
    for (int j = 1; j <= 8; j++) push(r + 10 + 4 * j, 2, K_RPT);
    push(r + 46, 2, K_FALL);
    push(r + 46, 2, K_HOFF);
    sig_in[2] = 1'b1;
    step_to(r + 9);
    @(negedge clk);
    check("held_before", held[2], 0);
    step_to(r + 10);
    @(negedge clk);
    check("held_level", held[2], 1);
    step_to(r + 40);
    sig_in[2] = 1'b0;
    drain();

    // ena strobing every 4th clk on ch3
    ena_mode = 1'b1;
    ena = ((cyc + 1) % 4 == 0);
    k = cyc;
    r = nth_en(k + 3, 4);
    push(r, 3, K_RISE);
    sig_in[3] = 1'b1;
    step_to(r - 1);
    @(negedge clk);
    check("ena_before", sig_debounced[3], 0);
    step_to(r);
    @(negedge clk);
    check("ena_level", sig_debounced[3], 1);
    step_to(r + 12);
    f = nth_en(cyc + 3, 4);
    push(f, 3, K_FALL);
    sig_in[3] = 1'b0;
    drain();
    ena_mode = 1'b0;
    ena = 1'b1;

    // Reset during ch2 repeat phase: outputs drop without a fall pulse
    k = cyc;
    r = k + 6;
    push(r, 2, K_RISE);
    push(r + 10, 2, K_RPT);
    push(r + 10, 2, K_HON);
    push(r + 14, 2, K_RPT);
    push(r + 17, 2, K_HOFF);
    sig_in[2] = 1'b1;
    step_to(r + 16);
    rst = 1'b1;
    sig_in[2] = 1'b0;
    step_to(r + 17);
    @(negedge clk);
    check("midrst_level", sig_debounced, 0);
    check("midrst_held", held, 0);
    check("midrst_rpt", rpt, 0);
    check("midrst_fall", fall, 0);
    step();
    rst = 1'b0;
    drain();

    // ch0 press coincident with ch1 release
    k = cyc;
    push(k + 6, 1, K_RISE);
    push(k + 14, 0, K_RISE);
    push(k + 14, 1, K_FALL);
    push(k + 22, 0, K_FALL);
    sig_in[1] = 1'b1;
    step_to(k + 8);
    sig_in[0] = 1'b1;
    sig_in[1] = 1'b0;
    step_to(k + 14);
    @(negedge clk);
    check("simul_rise", rise, 4'b0001);
    check("simul_fall", fall, 4'b0010);
    step_to(k + 16);
    sig_in[0] = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
